// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared WB control bit positions, zero-register index and default widths.
package wb_regfile_pkg;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int REG_ZERO    = 0;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;
endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// regfile_2r1w: two combinational read ports, one write port, register 0 hardwired to zero.
// rst is synchronous active-low and clears every entry.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    localparam int N = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [N];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
        end else if (we && waddr != ZERO) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == ZERO) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == ZERO) ? '0 : regs_q[raddr_b];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back mux, effective write generation, bypassed register file reads.
// Optional WB_RETIRE_CNT_EN adds RetireCnt, a wrapping count of committed register writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        WBin,
    input  logic [DATA_W-1:0] ADDin,
    input  logic [DATA_W-1:0] DMin,
    input  logic [ADDR_W-1:0] Rdin,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData,
    output logic [DATA_W-1:0] WBData,
    output logic [ADDR_W-1:0] WBRd,
    output logic              WBWe
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       RetireCnt
`endif
);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    wb_ctrl_t          wb;
    logic [DATA_W-1:0] rd_a, rd_b;

    assign wb     = wb_ctrl_t'(WBin);
    assign WBData = wb.mem_to_reg ? DMin : ADDin;
    assign WBWe   = rst && wb.reg_write && Rdin != ZERO;
    assign WBRd   = WBWe ? Rdin : '0;

    regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (WBWe),
        .waddr   (Rdin),
        .wdata   (WBData),
        .raddr_a (RsAddr),
        .raddr_b (RtAddr),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    // Reads are forced to zero during reset so stale storage never leaks before the clearing edge.
    assign RsData = !rst ? '0 : (WBWe && RsAddr == Rdin) ? WBData : rd_a;
    assign RtData = !rst ? '0 : (WBWe && RtAddr == Rdin) ? WBData : rd_b;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d     = cnt_q + {31'd0, WBWe};
    assign RetireCnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against an array-based reference model.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  WBin;
    logic [31:0] ADDin, DMin;
    logic [4:0]  Rdin, RsAddr, RtAddr;
    logic [31:0] RsData, RtData, WBData;
    logic [4:0]  WBRd;
    logic        WBWe;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] RetireCnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m [32];
    logic [31:0] m_cnt;

    wb_regfile dut (
        .clk    (clk),
        .rst    (rst),
        .WBin   (WBin),
        .ADDin  (ADDin),
        .DMin   (DMin),
        .Rdin   (Rdin),
        .RsAddr (RsAddr),
        .RtAddr (RtAddr),
        .RsData (RsData),
        .RtData (RtData),
        .WBData (WBData),
        .WBRd   (WBRd),
        .WBWe   (WBWe)
`ifdef WB_RETIRE_CNT_EN
        ,
        .RetireCnt (RetireCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic exp_we();
        return rst === 1'b1 && WBin[1] === 1'b1 && Rdin != 5'd0;
    endfunction

    function automatic logic [31:0] exp_wbd();
        return WBin[0] ? DMin : ADDin;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (rst !== 1'b1 || idx == 5'd0) return 32'd0;
        if (exp_we() && idx == Rdin) return exp_wbd();
        return m[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".WBData"}, WBData, exp_wbd());
        chk({tag, ".WBWe"}, {31'd0, WBWe}, {31'd0, exp_we()});
        chk({tag, ".WBRd"}, {27'd0, WBRd}, exp_we() ? {27'd0, Rdin} : 32'd0);
        chk({tag, ".RsData"}, RsData, exp_rd(RsAddr));
        chk({tag, ".RtData"}, RtData, exp_rd(RtAddr));
`ifdef WB_RETIRE_CNT_EN
        chk({tag, ".RetireCnt"}, RetireCnt, m_cnt);
`endif
    endtask

    task automatic tick();
        if (rst !== 1'b1) begin
            for (int i = 0; i < 32; i++) m[i] = 32'd0;
            m_cnt = 32'd0;
        end else if (exp_we()) begin
            m[Rdin] = exp_wbd();
            m_cnt   = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd);
        WBin = wb; ADDin = a; DMin = d; Rdin = rd;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        m_cnt = 32'd0;
        rst = 1'b0; RsAddr = 5'd5; RtAddr = 5'd31;
        drive(2'b10, 32'h5555_0000, 32'h0, 5'd7);
        check_all("in_reset");
        tick();
        tick();
        rst = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 5'd0);
        check_all("after_reset");
        chk("reset_rs5", RsData, 32'd0);
        chk("reset_rt31", RtData, 32'd0);

        drive(2'b10, 32'h0000_1234, 32'hDEAD_BEEF, 5'd8);
        RsAddr = 5'd8;
        check_all("alu_wb");
        chk("alu_wbdata", WBData, 32'h0000_1234);
        tick();
        drive(2'b00, 32'h0, 32'h0, 5'd0);
        check_all("alu_stored");
        chk("alu_rs8", RsData, 32'h0000_1234);

        drive(2'b11, 32'h0, 32'hCAFE_F00D, 5'd9);
        RtAddr = 5'd9;
        check_all("load_bypass");
        chk("load_bypass_rt", RtData, 32'hCAFE_F00D);
        chk("load_wbrd", {27'd0, WBRd}, 32'd9);
        tick();
        drive(2'b00, 32'h0, 32'h0, 5'd0);
        check_all("load_stored");
        chk("load_rt9", RtData, 32'hCAFE_F00D);

        drive(2'b10, 32'hFFFF_FFFF, 32'h0, 5'd0);
        RsAddr = 5'd0;
        check_all("zero_wr");
        chk("zero_we", {31'd0, WBWe}, 32'd0);
        tick();
        check_all("zero_after");
        chk("zero_rs0", RsData, 32'd0);

        drive(2'b10, 32'h11, 32'h0, 5'd3);
        tick();
        drive(2'b01, 32'h22, 32'h77, 5'd3);
        RsAddr = 5'd3;
        check_all("nowrite");
        chk("nowrite_wbdata", WBData, 32'h77);
        tick();
        check_all("nowrite_after");
        chk("nowrite_r3", RsData, 32'h11);
        drive(2'b10, 32'h33, 32'h0, 5'd4);
        rst = 1'b0;
        check_all("reset_mid");
        tick();
        rst = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 5'd0);
        RsAddr = 5'd3; RtAddr = 5'd4;
        check_all("reset_mid_after");
        chk("reset_mid_r3", RsData, 32'd0);
        chk("reset_mid_r4", RtData, 32'd0);

`ifdef WB_RETIRE_CNT_EN
        chk("cnt_zero", RetireCnt, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            drive(2'b10, 32'(i * 3), 32'h0, 5'(i));
            tick();
        end
        drive(2'b10, 32'h99, 32'h0, 5'd0);
        tick();
        drive(2'b01, 32'h99, 32'h98, 5'd6);
        tick();
        check_all("cnt_seq");
        chk("cnt_five", RetireCnt, 32'd5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_all("cnt_reset");
        chk("cnt_cleared", RetireCnt, 32'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 31) != 0);
            WBin = 2'($urandom);
            ADDin = $urandom;
            DMin = WBin[0] ? $urandom : 32'hxxxx_xxxx;
            Rdin = 5'($urandom);
            RsAddr = ($urandom_range(0, 3) == 0) ? Rdin : 5'($urandom);
            RtAddr = ($urandom_range(0, 3) == 0) ? RsAddr : 5'($urandom);
            check_all("rand");
            if (RsAddr == RtAddr) chk("rand_same", RsData, RtData);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and register file of the 5-stage MIPS pipeline.
- Sits at the read end of the MEM/WB pipeline register and consumes its WB control, ALU-result, memory-data and destination-register fields.
- Selects the write-back value, commits it to a 32-entry register file, and serves two combinational read ports to the ID stage.
- Read ports use write-through bypass so same-cycle ID reads see the WB value.

Parameters:
- DATA_W, 32, width of a register and of the write-back data.
- ADDR_W, 5, register index width; register count is 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (0 = reset).
- WBin  input  2  WB control from MEM/WB: bit1 = RegWrite, bit0 = MemtoReg.
- ADDin  input  DATA_W  ALU result from MEM/WB.
- DMin  input  DATA_W  data-memory read data from MEM/WB.
- Rdin  input  ADDR_W  destination register from MEM/WB.
- RsAddr  input  ADDR_W  ID read port A index.
- RtAddr  input  ADDR_W  ID read port B index.
- RsData  output  DATA_W  read port A data.
- RtData  output  DATA_W  read port B data.
- WBData  output  DATA_W  selected write-back value, for the EX forwarding mux.
- WBRd  output  ADDR_W  effective destination for the forwarding unit; 0 when no write occurs.
- WBWe  output  1  effective write enable: RegWrite AND (Rdin != 0).

Behaviour:
- Write-back select (combinational): WBData = DMin when WBin[0] = 1, else ADDin.
- Effective write: WBWe = WBin[1] & (Rdin != 0). WBRd = Rdin when WBWe = 1, else 0.
- Register commit: on rising clk with rst = 1 and WBWe = 1, regs[Rdin] <= WBData. Exactly one write per cycle. Write latency is 1 cycle into storage.
- Register 0: always reads 0. Writes to index 0 are discarded, and storage for index 0 is never modified.
- Read ports are combinational, with no clock latency:
  - If the index is 0, the port outputs 0.
  - Else if WBWe = 1 and the index equals Rdin, the port outputs WBData (write-through bypass).
  - Else the port outputs regs[index].
- Simultaneous events:
  - Both read ports hitting Rdin: both bypass.
  - RsAddr == RtAddr: identical data on both ports.
- Reset:
  - On rising clk with rst = 0, all registers are cleared to 0 and any write presented that cycle is dropped.
  - The combinational outputs still reflect their inputs during reset, except that bypass is suppressed: reads return 0 while rst = 0. WBWe is forced to 0 while rst = 0.
  - Reset asserted in the middle of a write sequence: the last pre-reset write is lost only if it coincides with the reset edge. Earlier writes are cleared by the reset.
- RegWrite = 0 with MemtoReg = 1: no write. WBData still shows DMin.
- X/Z on DMin is irrelevant when WBin[0] = 0. The mux must not propagate it.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- With the macro defined:
  - Adds output RetireCnt [31:0], a free-running count of committed writes.
  - RetireCnt increments by 1 on each clk edge with rst = 1 and WBWe = 1, and wraps from 0xFFFFFFFF to 0.
  - RetireCnt clears to 0 on reset.
  - Writes targeting register 0 do not count.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - WB control bit-position constants: WB_REGWRITE = 1, WB_MEMTOREG = 0.
  - REG_ZERO = 0.
  - Default DATA_W and ADDR_W.
- One sub-module is natural: regfile_2r1w. It holds the storage, the zero-register rule and the reset clear.
- wb_regfile wraps regfile_2r1w with the write-back mux, WBWe/WBRd generation, bypass and the optional counter.

Test Plan:
- Reset then read: rst = 0 for 2 cycles, release, RsAddr = 5, RtAddr = 31 -> RsData = RtData = 0.
- ALU write-back: WBin = 2'b10, ADDin = 0x0000_1234, DMin = 0xDEAD_BEEF, Rdin = 8, one cycle, then RsAddr = 8 -> WBData = 0x1234 during the write; RsData = 0x1234 afterwards.
- Load write-back with bypass: WBin = 2'b11, DMin = 0xCAFE_F00D, Rdin = 9, RtAddr = 9 in the same cycle -> RtData = 0xCAFE_F00D before the edge; storage holds the same value after the edge; WBWe = 1, WBRd = 9.
- Zero register: WBin = 2'b10, ADDin = 0xFFFF_FFFF, Rdin = 0 -> WBWe = 0, WBRd = 0; RsAddr = 0 reads 0 both before and after the edge.
- No-write and reset-mid-stream: write 0x11 to r3; then WBin = 2'b01, Rdin = 3, ADDin = 0x22 -> r3 stays 0x11. Assert rst = 0 on the same edge as a write of 0x33 to r4 -> r3 = r4 = 0 after release.
- WB_RETIRE_CNT_EN: 5 writes to r1..r5, plus one write to r0, plus one with RegWrite = 0 -> RetireCnt = 5. Reset -> RetireCnt = 0.
